// File: rtl/param_seq_datapath.sv
// Single-bus datapath with an internal micro-step sequencer and memory handshake.
// Define SEQ_DATAPATH_MUL_EN to enable the signed multiply (opcode 7) into HI/LO.
module param_seq_datapath #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int IMM_WIDTH  = 19
) (
   input  logic                        clock,
   input  logic                        clear_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_type,
   input  logic [3:0]                  cmd_op,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_rd,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_ra,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_rb,
   input  logic [IMM_WIDTH-1:0]        cmd_imm,
   output logic                        done,
   output logic                        err,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic                        mem_rd,
   output logic                        mem_wr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
   input  logic                        mem_ready,
   input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
   output logic [DATA_WIDTH-1:0]       dbg_data
);

   localparam int RW = $clog2(NUM_REGS);
   localparam logic [DATA_WIDTH-1:0] DW_MOD = DATA_WIDTH'(DATA_WIDTH);

   localparam logic [1:0] T_ALU = 2'd0;
   localparam logic [1:0] T_LD  = 2'd1;
   localparam logic [1:0] T_ST  = 2'd2;
   localparam logic [1:0] T_MF  = 2'd3;

   typedef enum logic [2:0] {
      IDLE, LD_RY, EXEC, WB, MEM_REQ, MEM_CAP, DONE
   } state_t;

   typedef struct packed {
      logic [1:0]           ctype;
      logic [3:0]           op;
      logic [RW-1:0]        rd;
      logic [RW-1:0]        ra;
      logic [RW-1:0]        rb;
      logic [IMM_WIDTH-1:0] imm;
   } cmd_t;

   state_t state;
   state_t nxt;
   cmd_t   cq;
   logic   accept;

   logic [DATA_WIDTH-1:0] rf [NUM_REGS];
   logic [DATA_WIDTH-1:0] ry;
   logic [DATA_WIDTH-1:0] rzl;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic [ADDR_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0] mdr;

   logic [DATA_WIDTH-1:0] opb;
   logic [DATA_WIDTH-1:0] shamt;
   logic [DATA_WIDTH-1:0] alu_lo;
   logic                  bad_op;

`ifdef SEQ_DATAPATH_MUL_EN
   logic [DATA_WIDTH-1:0]   rzh;
   logic [DATA_WIDTH-1:0]   alu_hi;
   logic [2*DATA_WIDTH-1:0] prod;
`endif

   assign accept    = cmd_valid && cmd_ready;
   assign opb       = rf[cq.rb];
   assign shamt     = opb % DW_MOD;
   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   assign dbg_data  = rf[dbg_sel];

`ifdef SEQ_DATAPATH_MUL_EN
   // Low 2W bits of sign-extended operands give the signed product.
   assign prod = {{DATA_WIDTH{ry[DATA_WIDTH-1]}}, ry}
               * {{DATA_WIDTH{opb[DATA_WIDTH-1]}}, opb};
`endif

   always_comb begin
      alu_lo = '0;
      bad_op = 1'b0;
`ifdef SEQ_DATAPATH_MUL_EN
      alu_hi = '0;
`endif
      case (cq.op)
         4'd0: alu_lo = ry + opb;
         4'd1: alu_lo = ry - opb;
         4'd2: alu_lo = ry & opb;
         4'd3: alu_lo = ry | opb;
         4'd4: alu_lo = ry ^ opb;
         4'd5: alu_lo = ry << shamt;
         4'd6: alu_lo = ry >> shamt;
`ifdef SEQ_DATAPATH_MUL_EN
         4'd7: {alu_hi, alu_lo} = prod;
`endif
         default: bad_op = 1'b1;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: begin
            nxt = IDLE;
            if (accept) begin
               case (cmd_type)
                  T_ALU:   nxt = LD_RY;
                  T_MF:    nxt = WB;
                  default: nxt = EXEC;
               endcase
            end
         end
         LD_RY: nxt = EXEC;
         EXEC: nxt = (cq.ctype == T_ALU) ? WB : MEM_REQ;
         MEM_REQ: begin
            if (mem_ready)
               nxt = (cq.ctype == T_ST) ? DONE : MEM_CAP;
         end
         MEM_CAP: nxt = WB;
         WB: nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
      end else begin
         state     <= nxt;
         cmd_ready <= (nxt == IDLE) || (nxt == DONE);
         done      <= (nxt == DONE);
         err       <= (nxt == DONE) && (cq.ctype == T_ALU) && bad_op;
         mem_rd    <= (nxt == MEM_REQ) && (cq.ctype == T_LD);
         mem_wr    <= (nxt == MEM_REQ) && (cq.ctype == T_ST);
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            rf[i] <= '0;
         cq  <= '0;
         ry  <= '0;
         rzl <= '0;
         hi  <= '0;
         lo  <= '0;
         mar <= '0;
         mdr <= '0;
`ifdef SEQ_DATAPATH_MUL_EN
         rzh <= '0;
`endif
      end else begin
         if (accept)
            cq <= '{cmd_type, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm};
         case (state)
            LD_RY: ry <= rf[cq.ra];
            EXEC: begin
               if (cq.ctype == T_ALU) begin
                  rzl <= alu_lo;
`ifdef SEQ_DATAPATH_MUL_EN
                  rzh <= alu_hi;
`endif
               end else begin
                  mar <= ADDR_WIDTH'(rf[cq.ra]
                         + DATA_WIDTH'($signed(cq.imm)));
                  if (cq.ctype == T_ST)
                     mdr <= opb;
               end
            end
            MEM_REQ: begin
               if (mem_ready && (cq.ctype == T_LD))
                  mdr <= mem_rdata;
            end
            WB: begin
               case (cq.ctype)
                  T_ALU: begin
                     if (!bad_op) begin
                        rf[cq.rd] <= rzl;
`ifdef SEQ_DATAPATH_MUL_EN
                        if (cq.op == 4'd7) begin
                           hi <= rzh;
                           lo <= rzl;
                        end
`endif
                     end
                  end
                  T_LD: rf[cq.rd] <= mdr;
                  T_MF: rf[cq.rd] <= cq.op[0] ? lo : hi;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_param_seq_datapath.sv
// Bench for param_seq_datapath: commands queued, expected results popped at done.
// Latency is the count of edges from accept to the edge that samples done high.
module tb_param_seq_datapath;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = '0;
   logic [3:0]  cmd_op = '0;
   logic [3:0]  cmd_rd = '0;
   logic [3:0]  cmd_ra = '0;
   logic [3:0]  cmd_rb = '0;
   logic [18:0] cmd_imm = '0;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [3:0]  dbg_sel = '0;
   logic [31:0] dbg_data;

   int errors = 0;
   int checks = 0;

   param_seq_datapath dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_type  (cmd_type),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_ra    (cmd_ra),
      .cmd_rb    (cmd_rb),
      .cmd_imm   (cmd_imm),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   always #5 clock = ~clock;

   // Memory responder: answers after mem_delay not-ready cycles.
   logic [31:0] rd_value = '0;
   int          mem_delay = 0;
   int          wait_cnt = 0;
   int          rd_cyc = 0;
   int          wr_cyc = 0;
   bit          prev_req = 0;
   bit          addr_moved = 0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   always @(negedge clock) begin
      if (mem_rd || mem_wr) begin
         if (!prev_req) begin
            req_addr   = mem_addr;
            req_wdata  = mem_wdata;
            addr_moved = 0;
         end else if (mem_addr !== req_addr || mem_wdata !== req_wdata) begin
            addr_moved = 1;
         end
         prev_req = 1;
         if (mem_rd) rd_cyc++;
         if (mem_wr) wr_cyc++;
         if (wait_cnt >= mem_delay) begin
            mem_ready = 1'b1;
            mem_rdata = rd_value;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = ~rd_value;
            wait_cnt++;
         end
      end else begin
         prev_req  = 0;
         mem_ready = 1'b0;
         mem_rdata = '0;
         wait_cnt  = 0;
      end
   end

   typedef struct {
      string       name;
      logic [1:0]  t;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [18:0] imm;
      logic [31:0] rdata;
      int          delay;
      bit          wr;
      logic [31:0] val;
      bit          err;
      int          lat;
      logic [31:0] addr;
      int          mcyc;
      logic [31:0] wdata;
   } cmd_s;

   cmd_s        pend[$];
   cmd_s        sb[$];
   logic [31:0] model [16];
   int          rd_base;
   int          wr_base;

   function automatic cmd_s f_ld(string n, logic [3:0] rd, logic [3:0] ra,
                                 logic [18:0] imm, logic [31:0] v,
                                 int dly, logic [31:0] a);
      cmd_s c;
      c = '{n, 2'd1, 4'd0, rd, ra, 4'd0, imm, v, dly, 1'b1, v, 1'b0,
            5 + dly, a, dly + 1, 32'd0};
      return c;
   endfunction

   function automatic cmd_s f_alu(string n, logic [3:0] op, logic [3:0] rd,
                                  logic [3:0] ra, logic [3:0] rb,
                                  logic [31:0] v, bit e);
      cmd_s c;
      c = '{n, 2'd0, op, rd, ra, rb, 19'd0, 32'd0, 0, !e, v, e,
            4, 32'd0, 0, 32'd0};
      return c;
   endfunction

   function automatic cmd_s f_st(string n, logic [3:0] ra, logic [3:0] rb,
                                 logic [18:0] imm, int dly, logic [31:0] a,
                                 logic [31:0] wd);
      cmd_s c;
      c = '{n, 2'd2, 4'd0, 4'd0, ra, rb, imm, 32'd0, dly, 1'b0, 32'd0,
            1'b0, 3 + dly, a, dly + 1, wd};
      return c;
   endfunction

   function automatic cmd_s f_mf(string n, logic [3:0] rd, bit sel,
                                 logic [31:0] v);
      cmd_s c;
      c = '{n, 2'd3, {3'd0, sel}, rd, 4'd0, 4'd0, 19'd0, 32'd0, 0, 1'b1, v,
            1'b0, 2, 32'd0, 0, 32'd0};
      return c;
   endfunction

   task automatic drive(input cmd_s c);
      cmd_type  = c.t;
      cmd_op    = c.op;
      cmd_rd    = c.rd;
      cmd_ra    = c.ra;
      cmd_rb    = c.rb;
      cmd_imm   = c.imm;
      rd_value  = c.rdata;
      mem_delay = c.delay;
      dbg_sel   = c.rd;
      rd_base   = rd_cyc;
      wr_base   = wr_cyc;
      cmd_valid = 1'b1;
   endtask

   // Issues every queued command; the next one is offered in the done cycle.
   task automatic run_pending();
      cmd_s        c;
      cmd_s        e;
      int          lat;
      int          good;
      int          bad;
      bit          more;
      logic [31:0] exp;
      if (pend.size() == 0) return;
      @(negedge clock);
      c = pend.pop_front();
      drive(c);
      sb.push_back(c);
      more = 1;
      while (more) begin
         @(posedge clock);
         lat = 0;
         do begin
            @(negedge clock);
            lat++;
            if (lat == 1) cmd_valid = 1'b0;
         end while (!done && lat < 200);
         e = sb.pop_front();
         checks++;
         if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
         end
         checks++;
         if (err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %0b want %0b", e.name, err, e.err);
         end
         exp = e.wr ? e.val : model[e.rd];
         checks++;
         if (dbg_data !== exp) begin
            errors++;
            $display("FAIL %s R%0d: got %h want %h", e.name, e.rd, dbg_data, exp);
         end
         if (e.wr) model[e.rd] = e.val;
         if (e.t == 2'd1 || e.t == 2'd2) begin
            good = (e.t == 2'd1) ? rd_cyc - rd_base : wr_cyc - wr_base;
            bad  = (e.t == 2'd1) ? wr_cyc - wr_base : rd_cyc - rd_base;
            checks++;
            if (req_addr !== e.addr) begin
               errors++;
               $display("FAIL %s mem_addr: got %h want %h", e.name, req_addr, e.addr);
            end
            checks++;
            if (good !== e.mcyc) begin
               errors++;
               $display("FAIL %s req cycles: got %0d want %0d", e.name, good, e.mcyc);
            end
            checks++;
            if (bad !== 0) begin
               errors++;
               $display("FAIL %s wrong strobe cycles: got %0d want 0", e.name, bad);
            end
            checks++;
            if (addr_moved !== 1'b0) begin
               errors++;
               $display("FAIL %s addr/wdata stable: got moved want stable", e.name);
            end
            if (e.t == 2'd2) begin
               checks++;
               if (req_wdata !== e.wdata) begin
                  errors++;
                  $display("FAIL %s mem_wdata: got %h want %h", e.name, req_wdata, e.wdata);
               end
            end
         end
         more = (pend.size() != 0);
         if (more) begin
            c = pend.pop_front();
            drive(c);
            sb.push_back(c);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) model[i] = '0;
      clear_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset ctl: got ready=%b done=%b err=%b want 1 0 0",
                  cmd_ready, done, err);
      end
      checks++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL reset mem: got rd=%b wr=%b want 0 0", mem_rd, mem_wr);
      end
      clear_n = 1'b1;
      @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle ready: got %b want 1", cmd_ready);
      end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1;
         checks++;
         if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset R%0d: got %h want 0", i, dbg_data);
         end
      end
   endtask

   task automatic test_alu();
      pend.push_back(f_ld("ld_r1", 4'd1, 4'd0, 19'd0, 32'd5, 0, 32'h0));
      pend.push_back(f_ld("ld_r2", 4'd2, 4'd0, 19'd0, 32'd7, 0, 32'h0));
      pend.push_back(f_alu("add", 4'd0, 4'd3, 4'd1, 4'd2, 32'd12, 0));
      pend.push_back(f_alu("sub", 4'd1, 4'd4, 4'd1, 4'd2, 32'hFFFFFFFE, 0));
      pend.push_back(f_alu("and", 4'd2, 4'd7, 4'd1, 4'd2, 32'd5, 0));
      pend.push_back(f_alu("or", 4'd3, 4'd8, 4'd1, 4'd2, 32'd7, 0));
      pend.push_back(f_alu("xor", 4'd4, 4'd9, 4'd1, 4'd2, 32'd2, 0));
      run_pending();
   endtask

   task automatic test_wrap_shift();
      pend.push_back(f_ld("ld_ones", 4'd1, 4'd0, 19'd0, 32'hFFFFFFFF, 0, 32'h0));
      pend.push_back(f_ld("ld_one", 4'd2, 4'd0, 19'd0, 32'd1, 0, 32'h0));
      pend.push_back(f_alu("add_wrap", 4'd0, 4'd3, 4'd1, 4'd2, 32'd0, 0));
      pend.push_back(f_alu("shl1", 4'd5, 4'd10, 4'd1, 4'd2, 32'hFFFFFFFE, 0));
      pend.push_back(f_ld("ld_33", 4'd11, 4'd0, 19'd0, 32'd33, 1, 32'h0));
      pend.push_back(f_alu("shr33", 4'd6, 4'd12, 4'd1, 4'd11, 32'h7FFFFFFF, 0));
      pend.push_back(f_alu("shr1", 4'd6, 4'd13, 4'd1, 4'd2, 32'h7FFFFFFF, 0));
      pend.push_back(f_alu("add_same", 4'd0, 4'd2, 4'd2, 4'd2, 32'd2, 0));
      run_pending();
   endtask

   task automatic test_load_wait();
      pend.push_back(f_ld("ld_base", 4'd4, 4'd0, 19'd0, 32'h100, 0, 32'h0));
      pend.push_back(f_ld("ld_wait3", 4'd5, 4'd4, 19'h7FFFC, 32'hDEADBEEF,
                          3, 32'hFC));
      run_pending();
   endtask

   task automatic test_store_back_to_back();
      pend.push_back(f_ld("ld_r6", 4'd6, 4'd0, 19'd0, 32'h55AA, 0, 32'h0));
      pend.push_back(f_st("store", 4'd4, 4'd6, 19'd8, 2, 32'h108, 32'h55AA));
      pend.push_back(f_alu("b2b_add", 4'd0, 4'd14, 4'd6, 4'd6, 32'hAB54, 0));
      pend.push_back(f_st("store0", 4'd0, 4'd5, 19'd4, 0, 32'h4, 32'hDEADBEEF));
      run_pending();
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1;
         checks++;
         if (dbg_data !== model[i]) begin
            errors++;
            $display("FAIL after store R%0d: got %h want %h", i, dbg_data, model[i]);
         end
      end
   endtask

   task automatic test_bad_op();
      pend.push_back(f_alu("bad12", 4'd12, 4'd3, 4'd1, 4'd2, 32'd0, 1));
      run_pending();
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1;
         checks++;
         if (dbg_data !== model[i]) begin
            errors++;
            $display("FAIL after bad op R%0d: got %h want %h", i, dbg_data, model[i]);
         end
      end
`ifdef SEQ_DATAPATH_MUL_EN
      pend.push_back(f_ld("ld_m3", 4'd1, 4'd0, 19'd0, 32'hFFFFFFFD, 0, 32'h0));
      pend.push_back(f_ld("ld_4", 4'd2, 4'd0, 19'd0, 32'd4, 0, 32'h0));
      pend.push_back(f_alu("mul", 4'd7, 4'd15, 4'd1, 4'd2, 32'hFFFFFFF4, 0));
      pend.push_back(f_mf("mfhi", 4'd13, 1'b0, 32'hFFFFFFFF));
      pend.push_back(f_mf("mflo", 4'd12, 1'b1, 32'hFFFFFFF4));
`else
      pend.push_back(f_alu("op7_off", 4'd7, 4'd15, 4'd1, 4'd2, 32'd0, 1));
      pend.push_back(f_mf("mfhi", 4'd13, 1'b0, 32'd0));
      pend.push_back(f_mf("mflo", 4'd12, 1'b1, 32'd0));
`endif
      run_pending();
   endtask

   task automatic test_reset_mid_load();
      int n;
      @(negedge clock);
      cmd_type  = 2'd1;
      cmd_rd    = 4'd9;
      cmd_ra    = 4'd4;
      cmd_rb    = 4'd0;
      cmd_imm   = 19'd0;
      rd_value  = 32'hCAFEF00D;
      mem_delay = 1000;
      dbg_sel   = 4'd9;
      cmd_valid = 1'b1;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (!mem_rd && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL mid req: got mem_rd=%b want 1", mem_rd);
      end
      @(negedge clock);
      #2 clear_n = 1'b0;
      #1;
      checks++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL async drop: got rd=%b wr=%b want 0 0", mem_rd, mem_wr);
      end
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid reset ctl: got ready=%b done=%b want 1 0", cmd_ready, done);
      end
      @(negedge clock);
      clear_n = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready after release: got %b want 1", cmd_ready);
      end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i);
         #1;
         checks++;
         if (dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL mid reset R%0d: got %h want 0", i, dbg_data);
         end
      end
      pend.push_back(f_ld("ld_recover", 4'd9, 4'd0, 19'd0, 32'h1234, 1, 32'h0));
      run_pending();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_wrap_shift();
      test_load_wait();
      test_store_back_to_back();
      test_bad_op();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
